lut_multiplier: RTL and testbench
=================================

# lut_multiplier

Signed 8×8 → 16-bit multiplier built on the quarter-square identity A·B = ⌊(A+B)²/4⌋ − ⌊(A−B)²/4⌋, with the squares read from a constant lookup table instead of a hardware multiplier. It is a multi-cycle arithmetic block with a start/done handshake. It also exposes its internal table indices and table outputs as observation ports for debug and verification.

## Interface
Parameters: none. All widths are fixed.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. Asynchronous and active-high.
- `start_sig` in 1: level request. Sampled only in IDLE.
- `A` in 8: signed two's-complement multiplicand.
- `B` in 8: signed two's-complement multiplier.
- `done_sig` out 1: one-cycle completion pulse.
- `product` out 16: signed result. Held until the next result.
- `I1_Sig` out 8: table index |A+B|.
- `I2_Sig` out 8: table index |A−B|.
- `Q1_Sig` out 16: table output ⌊I1²/4⌋.
- `Q2_Sig` out 16: table output ⌊I2²/4⌋.

## Operation
- Reset clears all outputs to 0 and sets the state to IDLE.
- The FSM has four states: IDLE → INDEX → SUB → DONE → IDLE.
- **IDLE:**
  - If `start_sig`=1, capture A and B.
  - Operand clamp: −128 is replaced by −127, so the working range is −127..+127.
  - Compute 9-bit signed sums s1=A+B and s2=A−B.
  - Register I1_Sig=|s1| and I2_Sig=|s2|. Both fit in 0..254.
  - Go to INDEX.
- **INDEX:**
  - Register Q1_Sig=LUT[I1_Sig] and Q2_Sig=LUT[I2_Sig].
  - Go to SUB.
- **SUB:**
  - Register product = Q1_Sig − Q2_Sig as a 16-bit two's-complement value.
  - Set done_sig=1 and go to DONE.
- **DONE:**
  - Clear done_sig to 0 and go to IDLE.
- LUT contents: 256 entries, LUT[n] = ⌊n²/4⌋ for n=0..255, 16-bit unsigned. The maximum entry is 16256.
- The subtraction is exact because s1 and s2 have equal parity. The result range is −16129..+16129, so there is no overflow.
- A, B and start_sig are ignored outside IDLE. The operation always completes once started.
- `product` and the debug outputs hold their values between operations.

## Timing
- Let e0 be the rising edge at which IDLE samples start_sig=1.
  - I1_Sig/I2_Sig are valid after e0.
  - Q1_Sig/Q2_Sig are valid after e0+1.
  - product is valid and done_sig=1 after e0+2.
  - done_sig returns to 0 after e0+3.
- Latency is 3 clocks from the sampling edge to done. done_sig is high for exactly one cycle.
- IDLE samples start_sig again at e0+4 at the earliest. A requester that drops start_sig on the edge where it sees done (e0+3) gets no repeat operation.
- If start_sig is still high at e0+4, a new operation starts with the current A and B. Back-to-back throughput is one result per 4 clocks.
- Asynchronous reset mid-operation aborts immediately: all outputs go to 0, the state goes to IDLE, and no done pulse is produced.

## Structure
- Shared package holds:
  - operand width (8), index width (8), result width (16)
  - LUT depth (256)
  - FSM state encoding (IDLE, INDEX, SUB, DONE)
- Sub-module `quarter_square_rom`:
  - combinational 256×16 ROM holding ⌊n²/4⌋
  - instantiated twice, once per index
  - contents generated by constant function or case table
- The parent holds the FSM, operand capture/clamp, abs logic and output registers.

## Test plan
- A=15, B=34 → I1=49, I2=19, Q1=600, Q2=90, product=510 (0x01FE); done 3 clocks after start sampled.
- A=−20 (0xEC), B=59 → I1=39, I2=79, Q1=380, Q2=1560, product=−1180 (0xFB64).
- A=−127 (0x81), B=127 → I1=0, I2=254, Q1=0, Q2=16129, product=−16129 (0xC0FF).
- A=−128, B=−128 → clamped to −127·−127; I1=254, I2=0, product=16129 (0x3F01). Also A=0, B=−77 → product=0.
- Start held through done, then dropped on the done edge → exactly one done pulse per request; the three sequences above run back-to-back with correct results.
- Assert rst in INDEX or SUB → all outputs 0 immediately, no done pulse. The next request after release completes normally.

Source files
------------

// File: rtl/lut_multiplier_pkg.sv
// Shared widths, table depth, FSM encoding and small helpers for lut_multiplier.
package lut_multiplier_pkg;

    localparam int OP_W      = 8;
    localparam int IDX_W     = 8;
    localparam int RES_W     = 16;
    localparam int LUT_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INDEX = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [RES_W-1:0] rom_t [LUT_DEPTH];

    // Quarter-square table, built at elaboration time: entry n = floor(n^2/4).
    function automatic rom_t build_rom();
        rom_t t;
        for (int n = 0; n < LUT_DEPTH; n++) begin
            t[n] = RES_W'((n * n) / 4);
        end
        return t;
    endfunction

    // -128 has no positive counterpart in 8 bits; folding it to -127 keeps
    // every |A+B| and |A-B| inside the 0..254 index range.
    function automatic logic [OP_W-1:0] clamp_op(input logic [OP_W-1:0] v);
        return (v == 8'h80) ? 8'h81 : v;
    endfunction

    // Magnitude of a 9-bit two's-complement sum known to lie in -254..254.
    function automatic logic [IDX_W-1:0] abs9(input logic [OP_W:0] v);
        return v[OP_W] ? (~v[IDX_W-1:0] + 8'd1) : v[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/lut_multiplier_quarter_square_rom.sv
// Combinational 256x16 constant ROM holding floor(n^2/4).
module quarter_square_rom
    import lut_multiplier_pkg::*;
(
    input  logic [IDX_W-1:0] index,
    output logic [RES_W-1:0] square
);

    localparam rom_t ROM = build_rom();

    assign square = ROM[index];

endmodule

// File: rtl/lut_multiplier.sv
// Signed 8x8 -> 16 multiplier using A*B = floor((A+B)^2/4) - floor((A-B)^2/4),
// with the squares read from constant ROMs. Four-state start/done sequencer.
module lut_multiplier
    import lut_multiplier_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_sig,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic             done_sig,
    output logic [RES_W-1:0] product,
    output logic [IDX_W-1:0] I1_Sig,
    output logic [IDX_W-1:0] I2_Sig,
    output logic [RES_W-1:0] Q1_Sig,
    output logic [RES_W-1:0] Q2_Sig
);

    state_t          state;
    logic [OP_W-1:0] a_c, b_c;
    logic [OP_W:0]   s1, s2;
    logic [IDX_W-1:0] i1_next, i2_next;
    logic [RES_W-1:0] q1_rom, q2_rom;

    // Clamp the live operands and form the two table indices; only used in IDLE.
    always_comb begin
        a_c     = clamp_op(A);
        b_c     = clamp_op(B);
        s1      = {a_c[OP_W-1], a_c} + {b_c[OP_W-1], b_c};
        s2      = {a_c[OP_W-1], a_c} - {b_c[OP_W-1], b_c};
        i1_next = abs9(s1);
        i2_next = abs9(s2);
    end

    quarter_square_rom u_rom1 (.index(I1_Sig), .square(q1_rom));
    quarter_square_rom u_rom2 (.index(I2_Sig), .square(q2_rom));

    // Sequencer: index -> table lookup -> subtract, one register stage each.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            done_sig <= 1'b0;
            product  <= '0;
            I1_Sig   <= '0;
            I2_Sig   <= '0;
            Q1_Sig   <= '0;
            Q2_Sig   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_sig) begin
                        I1_Sig <= i1_next;
                        I2_Sig <= i2_next;
                        state  <= INDEX;
                    end
                end
                INDEX: begin
                    Q1_Sig <= q1_rom;
                    Q2_Sig <= q2_rom;
                    state  <= SUB;
                end
                SUB: begin
                    // Equal parity of s1 and s2 makes the floored difference exact.
                    product  <= Q1_Sig - Q2_Sig;
                    done_sig <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_sig <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_multiplier.sv
// Self-checking bench for lut_multiplier: directed test-plan vectors, back-to-back
// requests, mid-operation reset, then randomized operands against an arithmetic model.
module tb_lut_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_sig;
    logic [7:0]  A, B;
    logic        done_sig;
    logic [15:0] product;
    logic [7:0]  I1_Sig, I2_Sig;
    logic [15:0] Q1_Sig, Q2_Sig;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int exp_done = 0;

    lut_multiplier dut (
        .clk(clk), .rst(rst), .start_sig(start_sig), .A(A), .B(B),
        .done_sig(done_sig), .product(product),
        .I1_Sig(I1_Sig), .I2_Sig(I2_Sig), .Q1_Sig(Q1_Sig), .Q2_Sig(Q2_Sig)
    );

    always #5 clk = ~clk;

    // Count every cycle in which done is high, sampled mid-cycle.
    always @(negedge clk) if (done_sig === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
            $error("%s miscompare", tag);
        end
    endtask

    // Reference model: plain integer arithmetic from the quarter-square rules.
    function automatic int op_val(input logic [7:0] v);
        int x;
        x = int'($signed(v));
        return (x == -128) ? -127 : x;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // One request, checked stage by stage. Entered and left at a falling edge.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit hold);
        int ai, bi, i1, i2;
        logic [15:0] p;
        ai = op_val(a); bi = op_val(b);
        i1 = iabs(ai + bi); i2 = iabs(ai - bi);
        p  = 16'(ai * bi);
        A = a; B = b; start_sig = 1'b1;
        @(negedge clk);                       // after e0
        check("I1", {8'h0, I1_Sig}, 16'(i1));
        check("I2", {8'h0, I2_Sig}, 16'(i2));
        check("done_e0", {15'h0, done_sig}, 16'd0);
        @(negedge clk);                       // after e0+1
        check("Q1", Q1_Sig, 16'((i1 * i1) / 4));
        check("Q2", Q2_Sig, 16'((i2 * i2) / 4));
        check("done_e1", {15'h0, done_sig}, 16'd0);
        @(negedge clk);                       // after e0+2
        check("product", product, p);
        check("done_e2", {15'h0, done_sig}, 16'd1);
        exp_done++;
        if (!hold) start_sig = 1'b0;
        A = 8'($urandom); B = 8'($urandom);   // ignored outside IDLE
        @(negedge clk);                       // after e0+3
        check("done_e3", {15'h0, done_sig}, 16'd0);
        check("product_hold", product, p);
    endtask

    initial begin
        rst = 1'b1; start_sig = 1'b0; A = '0; B = '0;
        @(negedge clk);
        check("rst_product", product, 16'd0);
        check("rst_I1", {8'h0, I1_Sig}, 16'd0);
        check("rst_Q2", Q2_Sig, 16'd0);
        check("rst_done", {15'h0, done_sig}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Test-plan vectors with literal expectations.
        do_op(8'd15, 8'd34, 1'b0);
        check("tp1_product", product, 16'h01FE);
        check("tp1_Q1", Q1_Sig, 16'd600);
        do_op(8'hEC, 8'd59, 1'b0);
        check("tp2_product", product, 16'hFB64);
        do_op(8'h81, 8'd127, 1'b0);
        check("tp3_product", product, 16'hC0FF);
        check("tp3_Q2", Q2_Sig, 16'd16129);
        do_op(8'h80, 8'h80, 1'b0);
        check("tp4_product", product, 16'h3F01);
        check("tp4_I1", {8'h0, I1_Sig}, 16'd254);
        do_op(8'd0, 8'hB3, 1'b0);
        check("tp5_product", product, 16'd0);

        // Back-to-back: start held through three operations, dropped on the last done.
        @(negedge clk);
        do_op(8'd15, 8'd34, 1'b1);
        do_op(8'hEC, 8'd59, 1'b1);
        do_op(8'h81, 8'd127, 1'b0);
        repeat (6) @(negedge clk);
        check("b2b_done_count", 16'(done_cnt), 16'(exp_done));
        check("b2b_idle_done", {15'h0, done_sig}, 16'd0);

        // Reset during INDEX, then during SUB: outputs clear at once, no done pulse.
        for (int k = 1; k <= 2; k++) begin
            A = 8'd100; B = 8'd7; start_sig = 1'b1;
            repeat (k) @(negedge clk);
            rst = 1'b1; start_sig = 1'b0;
            #1;
            check("arst_product", product, 16'd0);
            check("arst_I1", {8'h0, I1_Sig}, 16'd0);
            check("arst_Q1", Q1_Sig, 16'd0);
            check("arst_done", {15'h0, done_sig}, 16'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            check("arst_no_done", 16'(done_cnt), 16'(exp_done));
        end
        do_op(8'd100, 8'd7, 1'b0);
        check("post_rst_product", product, 16'd700);

        // Randomized operands, occasionally forcing the -128 and +-127 corners.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom); rb = 8'($urandom);
            if (i % 8 == 1) ra = 8'h80;
            if (i % 8 == 5) rb = 8'h7F;
            do_op(ra, rb, ($urandom_range(0, 1) == 1));
        end
        start_sig = 1'b0;
        repeat (6) @(negedge clk);
        check("final_done_count", 16'(done_cnt), 16'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
